// File: rtl/axis_req_latency_mon_pkg.sv
// Shared types and helpers for the request latency monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package latmon_pkg;

    // Admission state: RUN admits new packets, DRAIN holds SOPs until empty.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } latmon_state_e;

    // Default window depth and matching pointer width; the top overrides
    // both when it is built with a different MAX_OUTSTANDING.
    localparam int MAX_OUTSTANDING_DEF = 16;
    localparam int PTR_W               = $clog2(MAX_OUTSTANDING_DEF);

    // Saturating add on operands up to 64 bits wide. The result is clamped
    // at all-ones of the given width so the accumulator pins instead of
    // wrapping once it has filled.
    function automatic logic [63:0] sat_add(
        input logic [63:0] acc,
        input logic [63:0] inc,
        input int unsigned width
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << width) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/axis_req_latency_mon_if.sv
// AXI-Stream bundle used for the request input and output of the monitor.
// Latency: n/a (wiring only).
// Backpressure: tready from slave to master, standard valid/ready.
//
// Ports: tdata/tkeep/tuser/tlast/tvalid driven by the master, tready by the
// slave. tkeep is DATA_WIDTH/8 bits, tuser is USER_WIDTH bits.
interface axis_req_latency_mon_if #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (
        output tdata, tkeep, tuser, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_req_latency_mon_ts_fifo.sv
// Timestamp FIFO holding the accept time of each outstanding request.
// Latency: head_dat is valid combinationally from the stored entry; push visible next cycle.
// Backpressure: none; push-when-full and pop-when-empty are silently dropped.
//
// Ports: clk_390/rst_n clock and async active-low reset; push/push_dat write
// side; pop read side; head_dat oldest entry; count current occupancy.
module latmon_ts_fifo
    import latmon_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = MAX_OUTSTANDING_DEF,
    parameter int PW    = PTR_W
) (
    input  logic             clk_390,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [PW:0]      count
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != FULL_CNT);
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_390 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk_390) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/axis_req_latency_mon.sv
// Inline AXIS request gate with passive response tap measuring per-request latency.
// Latency: request data path is 0 cycles; statistics update 1 cycle after the response tlast.
// Backpressure: req_in_tready follows req_out_tready, forced low at SOP while the window is full or draining.
//
// Ports: clk_390 / clk_390_rst_n clock and async active-low reset;
// req_in (slave) / req_out (master) request stream; rsp_tvalid/tready/tlast
// response tap; barrier drain pulse; stat_clear synchronous stats clear;
// nr_req/nr_rsp packet counts; outstanding occupancy; lat_valid/lat_last/
// lat_min/lat_max/lat_sum latency statistics; err_underflow sticky error;
// draining barrier in progress.
// Optional macro LATMON_TIMEOUT_EN adds parameter TIMEOUT_CYCLES and outputs
// err_timeout (sticky) and timeout_count (one count per timed-out head).
module axis_req_latency_mon
    import latmon_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int TS_WIDTH        = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = 32,
    parameter int SUM_WIDTH       = 48
`ifdef LATMON_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic                             clk_390,
    input  logic                             clk_390_rst_n,
    axis_req_latency_mon_if.slave            req_in,
    axis_req_latency_mon_if.master           req_out,
    input  logic                             rsp_tvalid,
    input  logic                             rsp_tready,
    input  logic                             rsp_tlast,
    input  logic                             barrier,
    input  logic                             stat_clear,
    output logic [CNT_WIDTH-1:0]             nr_req,
    output logic [CNT_WIDTH-1:0]             nr_rsp,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             lat_valid,
    output logic [TS_WIDTH-1:0]              lat_last,
    output logic [TS_WIDTH-1:0]              lat_min,
    output logic [TS_WIDTH-1:0]              lat_max,
    output logic [SUM_WIDTH-1:0]             lat_sum,
    output logic                             err_underflow,
    output logic                             draining
`ifdef LATMON_TIMEOUT_EN
    , output logic                           err_timeout
    , output logic [CNT_WIDTH-1:0]           timeout_count
`endif
);

    localparam int          PW       = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_OUTSTANDING);

    latmon_state_e       state_q;
    latmon_state_e       state_d;
    logic [TS_WIDTH-1:0] ts_now;
    logic [TS_WIDTH-1:0] ts_head;
    logic [TS_WIDTH-1:0] lat_cur;
    logic [PW:0]         occ;
    logic [PW:0]         occ_after;
    logic                req_sop;
    logic                block;
    logic                gate;
    logic                req_fire;
    logic                push;
    logic                rsp_eop;
    logic                pop;
    logic                underflow;

    // ---------------- request path ----------------
    // Gating only ever bites at start-of-packet, so a packet that has begun
    // always runs to its tlast regardless of window or barrier state.
    assign block = (state_q == DRAIN) || (occ == FULL_CNT);
    assign gate  = req_sop & block;

    assign req_out.tdata  = req_in.tdata[DATA_WIDTH-1:0];
    assign req_out.tkeep  = req_in.tkeep[DATA_WIDTH/8-1:0];
    assign req_out.tuser  = req_in.tuser;
    assign req_out.tlast  = req_in.tlast;
    assign req_out.tvalid = req_in.tvalid & ~gate;
    assign req_in.tready  = req_out.tready & ~gate;

    assign req_fire = req_in.tvalid & req_in.tready;
    assign push     = req_fire & req_sop;

    // ---------------- response tap ----------------
    // A response only retires a request that was outstanding before this
    // cycle; a request pushed in the same cycle cannot satisfy it.
    assign rsp_eop   = rsp_tvalid & rsp_tready & rsp_tlast;
    assign pop       = rsp_eop & (occ != '0);
    assign underflow = rsp_eop & (occ == '0);

    assign lat_cur     = ts_now - ts_head;
    assign outstanding = occ;
    assign draining    = (state_q == DRAIN);

    latmon_ts_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (MAX_OUTSTANDING),
        .PW    (PW)
    ) u_ts_fifo (
        .clk_390  (clk_390),
        .rst_n    (clk_390_rst_n),
        .push     (push),
        .push_dat (ts_now),
        .pop      (pop),
        .head_dat (ts_head),
        .count    (occ)
    );

    // Free-running timestamp and SOP tracking of the request stream.
    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) begin
            ts_now  <= '0;
            req_sop <= 1'b1;
        end else begin
            ts_now <= ts_now + 1'b1;
            if (req_fire) req_sop <= req_in.tlast;
        end
    end

    // ---------------- drain FSM ----------------
    // No SOP can be pushed while in DRAIN, so occupancy after this cycle's
    // pop is the exit condition.
    assign occ_after = occ - (PW+1)'(pop);

    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) state_q <= RUN;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (barrier) state_d = DRAIN;
            DRAIN:   if (occ_after == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // ---------------- statistics ----------------
    // stat_clear takes priority over every update in the same cycle.
    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) begin
            nr_req        <= '0;
            nr_rsp        <= '0;
            lat_valid     <= 1'b0;
            lat_last      <= '0;
            lat_min       <= '1;
            lat_max       <= '0;
            lat_sum       <= '0;
            err_underflow <= 1'b0;
        end else if (stat_clear) begin
            nr_req        <= '0;
            nr_rsp        <= '0;
            lat_valid     <= 1'b0;
            lat_last      <= '0;
            lat_min       <= '1;
            lat_max       <= '0;
            lat_sum       <= '0;
            err_underflow <= 1'b0;
        end else begin
            lat_valid <= pop;
            if (push)      nr_req        <= nr_req + 1'b1;
            if (rsp_eop)   nr_rsp        <= nr_rsp + 1'b1;
            if (underflow) err_underflow <= 1'b1;
            if (pop) begin
                lat_last <= lat_cur;
                if (lat_cur < lat_min) lat_min <= lat_cur;
                if (lat_cur > lat_max) lat_max <= lat_cur;
                lat_sum <= SUM_WIDTH'(sat_add(64'(lat_sum), 64'(lat_cur),
                                              32'(SUM_WIDTH)));
            end
        end
    end

`ifdef LATMON_TIMEOUT_EN
    // ---------------- head-of-line timeout ----------------
    localparam logic [TS_WIDTH-1:0] TO_THR = TS_WIDTH'(TIMEOUT_CYCLES);

    logic to_hit;
    logic head_timed_out;

    assign to_hit = (occ != '0) && (lat_cur >= TO_THR);

    // Marks that the current head has already been counted; a pop moves to
    // a fresh head, so the mark is dropped then.
    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n)   head_timed_out <= 1'b0;
        else if (pop)         head_timed_out <= 1'b0;
        else if (to_hit)      head_timed_out <= 1'b1;
    end

    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) begin
            err_timeout   <= 1'b0;
            timeout_count <= '0;
        end else if (stat_clear) begin
            err_timeout   <= 1'b0;
            timeout_count <= '0;
        end else if (to_hit) begin
            err_timeout <= 1'b1;
            if (!head_timed_out) timeout_count <= timeout_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_req_latency_mon.sv
// Randomized self-checking bench for axis_req_latency_mon with a queue-based reference model.
// Latency: n/a.
// Backpressure: bench randomizes req_out_tready and holds request beats until accepted.
module tb_axis_req_latency_mon;

    localparam int DW   = 64;
    localparam int TSW  = 8;
    localparam int MAXO = 16;
    localparam int CW   = 32;
    localparam int SW   = 12;
    localparam int OW   = $clog2(MAXO) + 1;

    logic clk_390       = 1'b0;
    logic clk_390_rst_n = 1'b0;
    always #5 clk_390 = ~clk_390;

    axis_req_latency_mon_if #(.DATA_WIDTH(DW)) req_in ();
    axis_req_latency_mon_if #(.DATA_WIDTH(DW)) req_out ();

    logic           rsp_tvalid = 1'b0;
    logic           rsp_tready = 1'b0;
    logic           rsp_tlast  = 1'b0;
    logic           barrier    = 1'b0;
    logic           stat_clear = 1'b0;
    logic [CW-1:0]  nr_req;
    logic [CW-1:0]  nr_rsp;
    logic [OW-1:0]  outstanding;
    logic           lat_valid;
    logic [TSW-1:0] lat_last;
    logic [TSW-1:0] lat_min;
    logic [TSW-1:0] lat_max;
    logic [SW-1:0]  lat_sum;
    logic           err_underflow;
    logic           draining;
`ifdef LATMON_TIMEOUT_EN
    logic           err_timeout;
    logic [CW-1:0]  timeout_count;
`endif

    axis_req_latency_mon #(
        .DATA_WIDTH      (DW),
        .TS_WIDTH        (TSW),
        .MAX_OUTSTANDING (MAXO),
        .CNT_WIDTH       (CW),
        .SUM_WIDTH       (SW)
`ifdef LATMON_TIMEOUT_EN
        , .TIMEOUT_CYCLES (50)
`endif
    ) dut (
        .clk_390       (clk_390),
        .clk_390_rst_n (clk_390_rst_n),
        .req_in        (req_in),
        .req_out       (req_out),
        .rsp_tvalid    (rsp_tvalid),
        .rsp_tready    (rsp_tready),
        .rsp_tlast     (rsp_tlast),
        .barrier       (barrier),
        .stat_clear    (stat_clear),
        .nr_req        (nr_req),
        .nr_rsp        (nr_rsp),
        .outstanding   (outstanding),
        .lat_valid     (lat_valid),
        .lat_last      (lat_last),
        .lat_min       (lat_min),
        .lat_max       (lat_max),
        .lat_sum       (lat_sum),
        .err_underflow (err_underflow),
        .draining      (draining)
`ifdef LATMON_TIMEOUT_EN
        , .err_timeout   (err_timeout)
        , .timeout_count (timeout_count)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned    cyc;
        logic [TSW-1:0] lat;
    } exp_t;

    int unsigned    cyc;             // cycles since reset release == DUT timestamp
    logic [TSW-1:0] tsq [$];         // accept timestamps of outstanding requests
    exp_t           sb  [$];         // expected lat_valid strobes
    bit             m_sop   = 1'b1;
    bit             m_drain = 1'b0;
    logic [CW-1:0]  m_nr_req = '0;
    logic [CW-1:0]  m_nr_rsp = '0;
    logic [TSW-1:0] m_last = '0;
    logic [TSW-1:0] m_min  = '1;
    logic [TSW-1:0] m_max  = '0;
    int             m_sum  = 0;
    bit             m_uf   = 1'b0;

    always @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) cyc <= 0;
        else                cyc <= cyc + 1;
    end

    always @(negedge clk_390) begin : model
        bit             hold;
        bit             exp_rdy;
        bit             fire;
        int             occ_pre;
        logic [TSW-1:0] ts;
        logic [TSW-1:0] now;
        logic [TSW-1:0] lat;
        if (clk_390_rst_n) begin
            // registered outputs reflect everything applied up to last cycle
            chk("nr_req",        64'(nr_req),        64'(m_nr_req));
            chk("nr_rsp",        64'(nr_rsp),        64'(m_nr_rsp));
            chk("outstanding",   64'(outstanding),   64'(tsq.size()));
            chk("draining",      64'(draining),      64'(m_drain));
            chk("err_underflow", 64'(err_underflow), 64'(m_uf));
            chk("lat_last",      64'(lat_last),      64'(m_last));
            chk("lat_min",       64'(lat_min),       64'(m_min));
            chk("lat_max",       64'(lat_max),       64'(m_max));
            chk("lat_sum",       64'(lat_sum),       64'(m_sum));

            // admission: a new packet may not start while full or draining
            hold    = m_sop && (m_drain || tsq.size() == MAXO);
            exp_rdy = req_out.tready && !hold;
            chk("req_in_tready",  64'(req_in.tready),  64'(exp_rdy));
            chk("req_out_tvalid", 64'(req_out.tvalid), 64'(req_in.tvalid && !hold));
            chk("req_out_tdata",  req_out.tdata,       req_in.tdata);
            chk("req_out_tlast",  64'(req_out.tlast),  64'(req_in.tlast));

            occ_pre = tsq.size();
            now     = TSW'(cyc);
            fire    = req_in.tvalid && exp_rdy;
            if (fire && m_sop) begin
                tsq.push_back(now);
                m_nr_req = m_nr_req + 1;
            end
            if (fire) m_sop = req_in.tlast;

            if (rsp_tvalid && rsp_tready && rsp_tlast) begin
                m_nr_rsp = m_nr_rsp + 1;
                if (occ_pre > 0) begin
                    ts  = tsq.pop_front();
                    lat = now - ts;
                    if (!stat_clear) sb.push_back('{cyc: cyc, lat: lat});
                    m_last = lat;
                    if (lat < m_min) m_min = lat;
                    if (lat > m_max) m_max = lat;
                    m_sum = (m_sum + int'(lat) > (1 << SW) - 1) ? (1 << SW) - 1 : m_sum + int'(lat);
                end else begin
                    m_uf = 1'b1;
                end
            end

            if (m_drain) begin
                if (tsq.size() == 0) m_drain = 1'b0;
            end else if (barrier) begin
                m_drain = 1'b1;
            end

            if (stat_clear) begin
                m_nr_req = '0;
                m_nr_rsp = '0;
                m_last   = '0;
                m_min    = '1;
                m_max    = '0;
                m_sum    = 0;
                m_uf     = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor for lat_valid ----------------
    always @(negedge clk_390) begin : monitor
        exp_t e;
        if (clk_390_rst_n && lat_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("lat_valid_unexpected", 64'(lat_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("lat_valid_timing", 64'(cyc), 64'(e.cyc + 1));
                chk("lat_valid_value",  64'(lat_last), 64'(e.lat));
            end
        end
    end

    // ---------------- stimulus ----------------
    int p_req  = 0;   // percent chance to start a packet when idle
    int max_len = 1;
    int p_ordy = 100; // percent req_out_tready
    int p_rsp  = 0;   // percent rsp_tvalid
    int p_bar  = 0;   // permille barrier
    int p_clr  = 0;   // permille stat_clear
    int pkt_left = 0;

    task automatic run(input int n);
        bit fired;
        repeat (n) begin
            @(negedge clk_390);
            fired = req_in.tvalid && req_in.tready;
            @(posedge clk_390);
            #1;
            if (fired) pkt_left--;
            if (!req_in.tvalid || fired) begin
                if (pkt_left == 0 && ($urandom % 100) < p_req)
                    pkt_left = $urandom_range(1, max_len);
                if (pkt_left > 0) begin
                    req_in.tvalid = 1'b1;
                    req_in.tdata  = {$urandom, $urandom};
                    req_in.tkeep  = 8'($urandom);
                    req_in.tuser  = {$urandom, $urandom};
                    req_in.tlast  = (pkt_left == 1);
                end else begin
                    req_in.tvalid = 1'b0;
                    req_in.tlast  = 1'b0;
                end
            end
            req_out.tready = ($urandom % 100) < p_ordy;
            rsp_tvalid     = ($urandom % 100) < p_rsp;
            rsp_tready     = ($urandom % 4) != 0;
            rsp_tlast      = ($urandom % 2) != 0;
            barrier        = ($urandom % 1000) < p_bar;
            stat_clear     = ($urandom % 1000) < p_clr;
        end
    endtask

    initial begin
        req_in.tvalid  = 1'b0;
        req_in.tdata   = '0;
        req_in.tkeep   = '0;
        req_in.tuser   = '0;
        req_in.tlast   = 1'b0;
        req_out.tready = 1'b0;
        repeat (3) @(posedge clk_390);
        #1 clk_390_rst_n = 1'b1;

        // responses with nothing outstanding: underflow, counts only
        p_rsp = 60;
        run(20);
        p_rsp = 0;
        p_clr = 1000; run(1); p_clr = 0;
        run(3);

        // fill the window with single-beat requests and hold the overflow one
        p_req = 100; max_len = 1; p_ordy = 100;
        run(40);
        // release slowly with multi-beat traffic
        p_rsp = 30; max_len = 4;
        run(60);

        // directed barrier with traffic in flight
        p_bar = 1000; run(1); p_bar = 0;
        p_rsp = 20;
        run(80);

        // long randomized mix
        p_req = 60; max_len = 4; p_ordy = 70; p_rsp = 25; p_bar = 5; p_clr = 2;
        run(4000);

        // drain everything out
        p_req = 0; p_bar = 0; p_clr = 0; p_rsp = 80; p_ordy = 100;
        for (int i = 0; i < 500; i++) begin
            run(1);
            if (tsq.size() == 0 && pkt_left == 0) break;
        end
        p_rsp = 0;
        run(6);
        chk("drain_complete", 64'(tsq.size()), 64'd0);
        chk("final_outstanding", 64'(outstanding), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
